// File: rtl/rf_sb_pkg.sv
// Shared definitions for the register-file access scoreboard:
// query select codes and the saturating add.
package rf_sb_pkg;

  localparam int SEL_WR    = 0;
  localparam int SEL_RDTOT = 1;
  localparam int SEL_COL   = 2;
  localparam int SEL_RD0   = 3;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] inc,
    input int unsigned w
  );
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, inc};
    max = (33'd1 << w) - 33'd1;
    if (sum > max) sat_add = max[31:0];
    else           sat_add = sum[31:0];
  endfunction

endpackage

// File: rtl/rf_access_scoreboard_sat_counter.sv
// Saturating event counter with synchronous clear and
// multi-count increment.
module sat_counter
  import rf_sb_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = CNT_W'(sat_add(32'(cnt_q), 32'(inc), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/rf_access_scoreboard.sv
// Register-file access monitor: per-entry write/read/collision
// counters, uninitialised-read flag and a registered query port.
module rf_access_scoreboard
  import rf_sb_pkg::*;
#(
  parameter  int ADDR_BITS = 2,
  parameter  int NUM_RD    = 2,
  parameter  int CNT_W     = 16,
  localparam int SEL_W     = $clog2(NUM_RD + 3)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        count_en,
  input  logic                        clear,
  input  logic                        write_en,
  input  logic [ADDR_BITS-1:0]        write_addr,
  input  logic [NUM_RD-1:0]           read_en,
  input  logic [NUM_RD*ADDR_BITS-1:0] read_addr,
  input  logic                        query_valid,
  input  logic [ADDR_BITS-1:0]        query_addr,
  input  logic [SEL_W-1:0]            query_sel,
  output logic                        query_rvalid,
  output logic [CNT_W-1:0]            query_data,
  output logic                        uninit_read,
  output logic [ADDR_BITS-1:0]        uninit_addr,
  output logic                        sat_any
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int INC_W = $clog2(NUM_RD + 1);

  logic clr;
  logic go;
  assign clr = rst | clear;
  assign go  = count_en & ~clr;

  logic [ADDR_BITS-1:0] ra [NUM_RD];
  for (genvar p = 0; p < NUM_RD; p++) begin : g_ra
    assign ra[p] = read_addr[p*ADDR_BITS +: ADDR_BITS];
  end

  logic [INC_W-1:0] wr_inc  [DEPTH];
  logic [INC_W-1:0] tot_inc [DEPTH];
  logic [INC_W-1:0] col_inc [DEPTH];
  logic [INC_W-1:0] rd_inc  [NUM_RD][DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wr_inc[i]  = INC_W'(write_en && write_addr == ADDR_BITS'(i));
      tot_inc[i] = '0;
      col_inc[i] = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        rd_inc[p][i] = INC_W'(read_en[p] && ra[p] == ADDR_BITS'(i));
        tot_inc[i]   = tot_inc[i] + rd_inc[p][i];
        col_inc[i]   = col_inc[i] + (wr_inc[i] & rd_inc[p][i]);
      end
    end
  end

  logic [CNT_W-1:0] wr_cnt  [DEPTH];
  logic [CNT_W-1:0] tot_cnt [DEPTH];
  logic [CNT_W-1:0] col_cnt [DEPTH];
  logic [CNT_W-1:0] rd_cnt  [NUM_RD][DEPTH];
  logic [DEPTH-1:0] wr_sat;
  logic [DEPTH-1:0] tot_sat;
  logic [DEPTH-1:0] col_sat;
  logic [DEPTH-1:0] rd_sat [NUM_RD];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_wr (
      .clk(clk), .clr(clr), .en(go), .inc(wr_inc[i]),
      .cnt(wr_cnt[i]), .sat(wr_sat[i]));
    sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_tot (
      .clk(clk), .clr(clr), .en(go), .inc(tot_inc[i]),
      .cnt(tot_cnt[i]), .sat(tot_sat[i]));
    sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_col (
      .clk(clk), .clr(clr), .en(go), .inc(col_inc[i]),
      .cnt(col_cnt[i]), .sat(col_sat[i]));
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_rd (
        .clk(clk), .clr(clr), .en(go), .inc(rd_inc[p][i]),
        .cnt(rd_cnt[p][i]), .sat(rd_sat[p][i]));
    end
  end

  // Counters only clear together and never decrement, so OR of
  // their saturation is already sticky.
  always_comb begin
    sat_any = |{wr_sat, tot_sat, col_sat};
    for (int p = 0; p < NUM_RD; p++) begin
      sat_any = sat_any | (|rd_sat[p]);
    end
  end

  logic [DEPTH-1:0]     written_q, written_d;
  logic                 uninit_read_q, uninit_read_d;
  logic [ADDR_BITS-1:0] uninit_addr_q, uninit_addr_d;
  logic                 uhit;
  logic [ADDR_BITS-1:0] ufirst;

  // Written state is pre-edge, so a same-cycle write still reads old data.
  always_comb begin
    uhit   = 1'b0;
    ufirst = '0;
    for (int p = NUM_RD - 1; p >= 0; p--) begin
      if (read_en[p] && !written_q[ra[p]]) begin
        uhit   = 1'b1;
        ufirst = ra[p];
      end
    end
    written_d     = written_q;
    uninit_read_d = uninit_read_q;
    uninit_addr_d = uninit_addr_q;
    if (clr) begin
      written_d     = '0;
      uninit_read_d = 1'b0;
      uninit_addr_d = '0;
    end else if (go) begin
      if (write_en) written_d[write_addr] = 1'b1;
      if (uhit && !uninit_read_q) begin
        uninit_read_d = 1'b1;
        uninit_addr_d = ufirst;
      end
    end
  end

  logic [CNT_W-1:0] qd;
  logic             query_rvalid_q, query_rvalid_d;
  logic [CNT_W-1:0] query_data_q, query_data_d;

  always_comb begin
    qd = '0;
    case (query_sel)
      SEL_W'(SEL_WR):    qd = wr_cnt[query_addr];
      SEL_W'(SEL_RDTOT): qd = tot_cnt[query_addr];
      SEL_W'(SEL_COL):   qd = col_cnt[query_addr];
      default: begin
        for (int p = 0; p < NUM_RD; p++) begin
          if (query_sel == SEL_W'(SEL_RD0 + p)) qd = rd_cnt[p][query_addr];
        end
      end
    endcase
    query_rvalid_d = query_valid & ~clr;
    query_data_d   = query_rvalid_d ? qd : '0;
  end

  always_ff @(posedge clk) begin
    written_q      <= written_d;
    uninit_read_q  <= uninit_read_d;
    uninit_addr_q  <= uninit_addr_d;
    query_rvalid_q <= query_rvalid_d;
    query_data_q   <= query_data_d;
  end

  assign query_rvalid = query_rvalid_q;
  assign query_data   = query_data_q;
  assign uninit_read  = uninit_read_q;
  assign uninit_addr  = uninit_addr_q;

endmodule

// File: tb/tb_rf_access_scoreboard.sv
// Directed plus random bench for rf_access_scoreboard against an
// array-based reference model (ADDR_BITS=2, NUM_RD=2, CNT_W=4).
module tb_rf_access_scoreboard;

  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       rst, clear, count_en, write_en, query_valid;
  logic [1:0] write_addr, read_en, query_addr;
  logic [3:0] read_addr;
  logic [2:0] query_sel;
  logic       query_rvalid, uninit_read, sat_any;
  logic [3:0] query_data;
  logic [1:0] uninit_addr;

  int checks = 0;
  int errors = 0;

  int m_wr [4];
  int m_tot[4];
  int m_col[4];
  int m_rd [2][4];
  bit m_written[4];
  bit m_uninit;
  int m_uaddr;

  always #5 clk = ~clk;

  rf_access_scoreboard #(.ADDR_BITS(2), .NUM_RD(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .count_en(count_en), .clear(clear),
    .write_en(write_en), .write_addr(write_addr),
    .read_en(read_en), .read_addr(read_addr),
    .query_valid(query_valid), .query_addr(query_addr),
    .query_sel(query_sel), .query_rvalid(query_rvalid),
    .query_data(query_data), .uninit_read(uninit_read),
    .uninit_addr(uninit_addr), .sat_any(sat_any));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sinc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic int mq(input int a, input int s);
    case (s)
      0: return m_wr[a];
      1: return m_tot[a];
      2: return m_col[a];
      3: return m_rd[0][a];
      4: return m_rd[1][a];
      default: return 0;
    endcase
  endfunction

  function automatic bit msat();
    bit s = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_wr[i] == MAXC || m_tot[i] == MAXC || m_col[i] == MAXC) s = 1;
      if (m_rd[0][i] == MAXC || m_rd[1][i] == MAXC) s = 1;
    end
    return s;
  endfunction

  task automatic model_update();
    int a [2];
    a[0] = int'(read_addr[1:0]);
    a[1] = int'(read_addr[3:2]);
    if (rst || clear) begin
      for (int i = 0; i < 4; i++) begin
        m_wr[i] = 0; m_tot[i] = 0; m_col[i] = 0;
        m_rd[0][i] = 0; m_rd[1][i] = 0; m_written[i] = 0;
      end
      m_uninit = 0;
      m_uaddr  = 0;
    end else if (count_en) begin
      for (int p = 0; p < 2; p++) begin
        if (read_en[p] && !m_written[a[p]] && !m_uninit) begin
          m_uninit = 1;
          m_uaddr  = a[p];
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (read_en[p]) begin
          m_rd[p][a[p]] = sinc(m_rd[p][a[p]]);
          m_tot[a[p]]   = sinc(m_tot[a[p]]);
          if (write_en && a[p] == int'(write_addr))
            m_col[a[p]] = sinc(m_col[a[p]]);
        end
      end
      if (write_en) begin
        m_wr[write_addr]      = sinc(m_wr[write_addr]);
        m_written[write_addr] = 1;
      end
    end
  endtask

  task automatic step();
    bit ev;
    int ed;
    ev = query_valid && !rst && !clear;
    ed = ev ? mq(int'(query_addr), int'(query_sel)) : 0;
    @(posedge clk);
    model_update();
    #1;
    chk("rvalid", int'(query_rvalid), int'(ev));
    if (ev) chk("qdata", int'(query_data), ed);
    chk("uninit_read", int'(uninit_read), int'(m_uninit));
    chk("uninit_addr", int'(uninit_addr), m_uaddr);
    chk("sat_any", int'(sat_any), int'(msat()));
  endtask

  task automatic idle();
    rst = 0; clear = 0; count_en = 1;
    write_en = 0; write_addr = 0;
    read_en = 0; read_addr = 0;
    query_valid = 0; query_addr = 0; query_sel = 0;
  endtask

  task automatic wr(input int a);
    idle();
    write_en = 1; write_addr = 2'(a);
    step();
  endtask

  task automatic rd(input logic [1:0] en, input int a0, input int a1);
    idle();
    read_en = en; read_addr = {2'(a1), 2'(a0)};
    step();
  endtask

  task automatic qry(input int a, input int s);
    idle();
    query_valid = 1; query_addr = 2'(a); query_sel = 3'(s);
    step();
  endtask

  initial begin
    idle();
    rst = 1;
    step();
    step();
    qry(1, 0);
    chk("reset_q_wr", int'(query_data), 0);

    wr(1); wr(1); wr(1);
    rd(2'b01, 1, 0); rd(2'b01, 1, 0); rd(2'b10, 0, 1);
    qry(1, 0); chk("wr1", int'(query_data), 3);
    qry(1, 1); chk("rdtot1", int'(query_data), 3);
    qry(1, 3); chk("rd0_1", int'(query_data), 2);
    qry(1, 4); chk("rd1_1", int'(query_data), 1);
    qry(1, 2); chk("col1", int'(query_data), 0);
    chk("no_uninit", int'(uninit_read), 0);

    idle();
    write_en = 1; write_addr = 2; read_en = 2'b11; read_addr = {2'd2, 2'd2};
    step();
    qry(2, 1); chk("rdtot2", int'(query_data), 2);
    qry(2, 2); chk("col2", int'(query_data), 2);
    chk("uninit_set", int'(uninit_read), 1);
    chk("uninit_addr2", int'(uninit_addr), 2);

    idle();
    rst = 1; query_valid = 1; query_addr = 1;
    step();
    chk("rst_rvalid", int'(query_rvalid), 0);
    for (int a = 1; a <= 2; a++)
      for (int s = 0; s <= 4; s++) begin
        qry(a, s);
        chk("post_rst_zero", int'(query_data), 0);
      end
    chk("post_rst_uninit", int'(uninit_read), 0);

    for (int n = 1; n <= 20; n++) begin
      wr(0);
      if (n == 14) chk("sat_before", int'(sat_any), 0);
      if (n >= 15) chk("sat_after", int'(sat_any), 1);
    end
    qry(0, 0); chk("wr0_sat", int'(query_data), 15);

    wr(3);
    for (int n = 0; n < 5; n++) begin
      idle();
      count_en = 0; write_en = 1; write_addr = 3;
      query_valid = 1; query_addr = 3; query_sel = 0;
      step();
      chk("freeze_rvalid", int'(query_rvalid), 1);
      chk("freeze_data", int'(query_data), 1);
    end
    qry(3, 0); chk("freeze_hold", int'(query_data), 1);
    idle();
    clear = 1; write_en = 1; write_addr = 3;
    step();
    qry(3, 0); chk("clear_wins", int'(query_data), 0);

    qry(1, 7);
    chk("bad_sel_valid", int'(query_rvalid), 1);
    chk("bad_sel_data", int'(query_data), 0);
    for (int k = 0; k < 4; k++) begin
      qry(k, 0);
      chk("b2b_valid", int'(query_rvalid), 1);
    end

    for (int n = 0; n < 400; n++) begin
      idle();
      rst         = ($urandom % 64) == 0;
      clear       = ($urandom % 32) == 0;
      count_en    = ($urandom % 4) != 0;
      write_en    = 1'($urandom);
      write_addr  = 2'($urandom);
      read_en     = 2'($urandom);
      read_addr   = 4'($urandom);
      query_valid = 1'($urandom);
      query_addr  = 2'($urandom);
      query_sel   = 3'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
